// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage. Owns the PC, looks up the instruction cache and
//   presents pc/instruction/valid to the fetch->decode pipeline register.
//   Obeys stall from the hazard unit and redirect (branch/flush) from execute.
//
//   Parameters
//     WORD_SIZE   width of PC, addresses and instruction words (`WORD_SIZE)
//     RESET_PC    PC loaded on reset
//     PC_STEP     sequential PC increment in bytes
//
//   Ports
//     clk, reset                  clock, synchronous active-high reset
//     stall                       F/D cannot accept; hold presented instruction
//     branch_taken/branch_target  redirect request and new PC
//     icache_addr/icache_req      lookup address and request
//     icache_hit/icache_data      same-cycle hit and instruction word
//     icache_fill_done            one-cycle pulse when a miss line is installed
//     pc_out/instruction_out      presented instruction to F/D
//     valid_out                   presented instruction is real
//
//   Optional build macro FETCH_PERF_CNT_EN adds the saturating 32-bit
//   counters perf_fetched (accepted instructions) and perf_miss_cycles
//   (cycles spent in MISS_WAIT).
//
//   State      | meaning
//   -----------+------------------------------------------------------------
//   FETCH      | looking up pc; presents instruction on hit
//   MISS_WAIT  | waiting for fill of miss_addr; nothing presented
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module fetch_stage #(
    parameter int unsigned          WORD_SIZE = `WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(32'h1000),
    parameter int unsigned          PC_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic [WORD_SIZE-1:0] icache_addr,
    output logic                 icache_req,
    input  logic                 icache_hit,
    input  logic [WORD_SIZE-1:0] icache_data,
    input  logic                 icache_fill_done,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] instruction_out,
    output logic                 valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_miss_cycles
`endif
);

    typedef enum logic {
        ST_FETCH     = 1'b0,
        ST_MISS_WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d;
    logic [WORD_SIZE-1:0]   miss_addr_q, miss_addr_d;
    logic                   accept;

    // Outputs are combinational from state and the same-cycle cache response.
    always_comb begin
        pc_out          = pc_q;
        instruction_out = reset ? '0 : icache_data;
        icache_req      = ~reset;
        icache_addr     = (state_q == ST_MISS_WAIT) ? miss_addr_q : pc_q;
        valid_out       = (state_q == ST_FETCH) & icache_hit & ~branch_taken & ~reset;
    end

    // F/D takes the instruction only when it is valid and not stalled; the PC
    // must never advance on any other condition.
    assign accept = valid_out & ~stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            ST_FETCH: begin
                if (branch_taken) begin
                    // A miss on the wrong path is dropped, not filled.
                    pc_d = branch_target;
                end else if (!icache_hit) begin
                    miss_addr_d = pc_q;
                    state_d     = ST_MISS_WAIT;
                end else if (!stall) begin
                    pc_d = pc_q + WORD_SIZE'(PC_STEP);
                end
            end
            ST_MISS_WAIT: begin
                // The fill cannot be aborted; a redirect only retargets pc so
                // fetch resumes on the new path once the line is installed.
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                if (icache_fill_done) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_miss_cycles_q;

    assign perf_fetched     = perf_fetched_q;
    assign perf_miss_cycles = perf_miss_cycles_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            miss_addr_q <= '0;
`ifdef FETCH_PERF_CNT_EN
            perf_fetched_q     <= '0;
            perf_miss_cycles_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
`ifdef FETCH_PERF_CNT_EN
            if (accept && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((state_q == ST_MISS_WAIT) && (perf_miss_cycles_q != '1)) begin
                perf_miss_cycles_q <= perf_miss_cycles_q + 32'd1;
            end
`endif
        end
    end

`ifndef FETCH_PERF_CNT_EN
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
